// File: rtl/apb_master_seq_if.sv
// apb_master_seq_if
//   Groups the command/response handshake and the APB3 bus of apb_master_seq.
//   master modport: the sequencer's view (drives cmd_ready, rsp_*, busy, APB request side).
//   slave modport : the environment's view (LSU command side and APB peripherals).
//   Parameters must match the ones given to apb_master_seq.
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_sel  command handshake
//     rsp_valid/rsp_rdata/rsp_err                               completion response
//     busy                                                      transfer in SETUP/ACCESS
//     psel/penable/pwrite/paddr/pwdata                          APB request
//     prdata/pready/pslverr                                     per-slave APB return
interface apb_master_seq_if #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 2
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [DATA_W-1:0]         cmd_wdata;
  logic [1:0]                cmd_sel;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      busy;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_sel,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_seq.sv
// apb_master_seq
//   Runs one APB3 transfer (IDLE -> SETUP -> ACCESS) per accepted command and
//   returns a one-cycle response. Drives a one-hot PSEL to NUM_SLV slaves and
//   observes only the selected slave's PREADY/PSLVERR/PRDATA.
//   Optional feature macro: APB_TIMEOUT_EN -- adds a 16-bit ACCESS wait counter
//   that aborts the transfer (err=1, rdata=0) after TIMEOUT_CYC wait cycles.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous reset, active-low
//     bus    apb_master_seq_if.master (command, response, APB bus)
//
//   state     | meaning
//   ST_IDLE   | ready for a command; response pulses are issued here
//   ST_SETUP  | psel high, penable low, exactly one cycle
//   ST_ACCESS | psel and penable high until selected pready (or timeout)
module apb_master_seq #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  apb_master_seq_if.master   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t              state, state_nxt;
  logic                sel_ok;
  logic                accept_ok, accept_bad, done, abort;
  logic                cmd_ready, busy, psel_on, penable;
  logic                limit;
  logic [NUM_SLV-1:0]  sel_oh, sel_oh_nxt;
  logic                pready_s, pslverr_s;
  logic [DATA_W-1:0]   prdata_s;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  assign sel_ok = (int'(bus.cmd_sel) < NUM_SLV);

  always_comb begin
    sel_oh_nxt = '0;
    for (int k = 0; k < NUM_SLV; k++) sel_oh_nxt[k] = (int'(bus.cmd_sel) == k);
  end

  // the registered one-hot select masks off every unselected slave
  always_comb begin
    pready_s  = |(bus.pready & sel_oh);
    pslverr_s = |(bus.pslverr & sel_oh);
    prdata_s  = '0;
    for (int k = 0; k < NUM_SLV; k++)
      if (sel_oh[k]) prdata_s = prdata_s | bus.prdata[k*DATA_W +: DATA_W];
  end

`ifdef APB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // limit is hit on the TIMEOUT_CYC-th ACCESS cycle; pready in that cycle still wins
  assign limit = (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                          wait_cnt <= '0;
    else if (state == ST_SETUP)          wait_cnt <= '0;
    else if (state == ST_ACCESS && !pready_s) wait_cnt <= wait_cnt + 16'd1;
  end
`else
  // no counter: the compare is constant false, ACCESS waits for pready forever
  assign limit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    psel_on    = 1'b0;
    penable    = 1'b0;
    accept_ok  = 1'b0;
    accept_bad = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (sel_ok) begin
            accept_ok = 1'b1;
            state_nxt = ST_SETUP;
          end else begin
            accept_bad = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        busy      = 1'b1;
        psel_on   = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy    = 1'b1;
        psel_on = 1'b1;
        penable = 1'b1;
        if (pready_s) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (limit) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sel_oh      <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= accept_bad | done | abort;
      if (accept_ok) begin
        sel_oh   <= sel_oh_nxt;
        pwrite_q <= bus.cmd_write;
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_wdata;
      end
      if (accept_bad || abort) begin
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end else if (done) begin
        rsp_err_q <= pslverr_s;
        if (!pwrite_q) rsp_rdata_q <= prdata_s;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = busy;
  assign bus.psel      = psel_on ? sel_oh : '0;
  assign bus.penable   = penable;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_seq.sv
// tb_apb_master_seq
//   Randomized bench for apb_master_seq. Expected latency, enable length, error
//   and read data come from a transfer-level model (latency arithmetic plus a
//   held read-data variable). Build with APB_TIMEOUT_EN to also cover aborts.
module tb_apb_master_seq;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 2;
`ifdef APB_TIMEOUT_EN
  localparam int TO_CYC = 4;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO_CYC = 255;
  localparam bit TO_EN  = 1'b0;
`endif
  localparam int NEVER  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] exp_rdata = '0;

  always #5 clk = ~clk;

  apb_master_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV)) bus ();

  apb_master_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic scramble_cmd();
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = ADDR_W'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_sel   = 2'($urandom);
  endtask

  task automatic scramble_slaves();
    for (int k = 0; k < NUM_SLV; k++) begin
      bus.pready[k]                  = 1'($urandom);
      bus.pslverr[k]                 = 1'($urandom);
      bus.prdata[k*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  // Issue one command and follow it to its response.
  //   gap   : idle cycles before issuing (0 = accept in the current/response cycle)
  //   waits : selected slave holds pready low this many ACCESS cycles
  task automatic run_cmd(input int gap, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input int sel, input int waits,
                         input bit serr, input logic [DATA_W-1:0] rd_val);
    bit valid, err_exp, got;
    int lat, pen_exp, n, pen_cyc;
    logic [DATA_W-1:0] rd_exp;

    valid = (sel < NUM_SLV);
    if (!valid) begin
      lat = 1; pen_exp = 0; err_exp = 1'b1; rd_exp = '0;
    end else if (TO_EN && waits >= TO_CYC) begin
      lat = TO_CYC + 2; pen_exp = TO_CYC; err_exp = 1'b1; rd_exp = '0;
    end else begin
      lat = waits + 3; pen_exp = waits + 1; err_exp = serr;
      rd_exp = wr ? exp_rdata : rd_val;
    end

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
      chk("idle_rdata_hold", bus.rsp_rdata, exp_rdata);
      chk("idle_psel", bus.psel, 0);
    end
    chk("cmd_ready", bus.cmd_ready, 1);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_sel   = 2'(sel);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    scramble_cmd();

    n = 0; got = 1'b0; pen_cyc = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) begin
        got = 1'b1;
      end else begin
        chk("busy", bus.busy, 1);
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        chk("psel", bus.psel, valid ? (64'(1) << sel) : 64'(0));
        chk("penable", bus.penable, n >= 2);
        chk("paddr", bus.paddr, addr);
        chk("pwdata", bus.pwdata, wd);
        chk("pwrite", bus.pwrite, wr);
        if (bus.penable) pen_cyc++;
        scramble_slaves();
        if (valid && n >= 2) begin
          bus.pready[sel]                  = (n - 1 > waits);
          bus.pslverr[sel]                 = serr;
          bus.prdata[sel*DATA_W +: DATA_W] = rd_val;
        end
        bus.cmd_valid = 1'($urandom);
        scramble_cmd();
      end
    end
    bus.cmd_valid = 1'b0;

    chk("rsp_seen", got, 1);
    if (got) begin
      chk("latency", n, lat);
      chk("penable_cycles", pen_cyc, pen_exp);
      chk("rsp_err", bus.rsp_err, err_exp);
      chk("rsp_rdata", bus.rsp_rdata, rd_exp);
      chk("rsp_psel", bus.psel, 0);
      chk("rsp_penable", bus.penable, 0);
      chk("rsp_busy", bus.busy, 0);
      chk("rsp_cmd_ready", bus.cmd_ready, 1);
    end
    exp_rdata = rd_exp;
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h11;
    bus.cmd_sel   = 2'd1;
    bus.pready    = '0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_penable", bus.penable, 1);
    rst = 1'b0;
    #1;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    bus.pready = '1;
    exp_rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);
      chk("post_rst_cmd_ready", bus.cmd_ready, 1);
      chk("post_rst_psel", bus.psel, 0);
      chk("post_rst_rdata", bus.rsp_rdata, 0);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    scramble_cmd();
    scramble_slaves();
    #3 rst = 1'b0;
    #4;
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_psel", bus.psel, 0);
    chk("reset_penable", bus.penable, 0);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);
    @(negedge clk);
    rst = 1'b1;

    // zero-wait write to UART
    run_cmd(1, 1'b1, 5'h04, 32'hA5A5_0001, 0, 0, 1'b0, 32'h0);
    // read from slave 1 with three wait states
    run_cmd(1, 1'b0, 5'h08, 32'h0, 1, 3, 1'b0, 32'hDEAD_BEEF);
    // slave error on read, then a back-to-back write accepted in the response cycle
    run_cmd(1, 1'b0, 5'h0C, 32'h0, 0, 1, 1'b1, 32'h1234_5678);
    run_cmd(0, 1'b1, 5'h10, 32'h0BAD_F00D, 1, 0, 1'b0, 32'hFFFF_FFFF);
    // invalid selects
    run_cmd(0, 1'b0, 5'h1F, 32'h0, 2, 0, 1'b0, 32'h0);
    run_cmd(1, 1'b1, 5'h01, 32'h5, 3, 0, 1'b0, 32'h0);
    // write keeps previous read data
    run_cmd(1, 1'b0, 5'h02, 32'h0, 0, 0, 1'b0, 32'hCAFE_0042);
    run_cmd(0, 1'b1, 5'h03, 32'h7777_7777, 0, 2, 1'b0, 32'h0);
`ifdef APB_TIMEOUT_EN
    run_cmd(1, 1'b0, 5'h05, 32'h0, 1, NEVER, 1'b0, 32'h9999_9999);
    run_cmd(0, 1'b0, 5'h06, 32'h0, 0, TO_CYC - 1, 1'b0, 32'h4242_4242);
    run_cmd(1, 1'b1, 5'h07, 32'h1, 0, NEVER, 1'b1, 32'h0);
`endif

    reset_mid_access();

    for (int i = 0; i < 60; i++) begin
      int waits;
      waits = $urandom_range(0, 5);
      if (TO_EN && $urandom_range(0, 5) == 0) waits = NEVER;
      run_cmd($urandom_range(0, 2), 1'($urandom), ADDR_W'($urandom), $urandom,
              $urandom_range(0, 3), waits, 1'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
